// File: rtl/rob_alloc_ctrl.sv
// rob_alloc_ctrl: allocation / completion / retirement control for a
// DEPTH-entry reorder buffer.
//
// Ports:
//   i_clk, i_rst          clock (rising), async active-high reset
//   i_alloc_cnt           0/1/2 entries requested (3 behaves as 0)
//   o_alloc_ok            comb grant, all-or-nothing
//   o_alloc_id0/1         comb ROB numbers at tail / tail+1
//   i_cpl_valid/i_cpl_id  CPL_N completion ports
//   i_flush               sync flush, wins over everything
//   o_retire_valid/_id    registered, up to 2 in-order retirements
//   o_count/o_full/o_empty occupancy
//
// rob_entry holds the valid/complete bits of one entry; the top instantiates
// one per ROB slot and computes the per-entry strobes.

module rob_entry (
    input  logic i_clk,
    input  logic i_rst,
    input  logic flush,
    input  logic alloc_set,
    input  logic cpl_hit,
    input  logic retire_clr,
    output logic valid,
    output logic complete
);
    // Allocation only targets free entries and retirement only valid ones, so
    // alloc_set and retire_clr never coincide. Completion is gated by the
    // pre-edge valid, which drops completions aimed at an entry being
    // allocated on the same edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid    <= 1'b0;
            complete <= 1'b0;
        end else if (flush || retire_clr) begin
            valid    <= 1'b0;
            complete <= 1'b0;
        end else if (alloc_set) begin
            valid    <= 1'b1;
            complete <= 1'b0;
        end else if (cpl_hit && valid) begin
            complete <= 1'b1;
        end
    end
endmodule

module rob_alloc_ctrl #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4,
    parameter int CPL_N = 3
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [1:0]                  i_alloc_cnt,
    output logic                        o_alloc_ok,
    output logic [PTR_W-1:0]            o_alloc_id0,
    output logic [PTR_W-1:0]            o_alloc_id1,
    input  logic [CPL_N-1:0]            i_cpl_valid,
    input  logic [CPL_N-1:0][PTR_W-1:0] i_cpl_id,
    input  logic                        i_flush,
    output logic [1:0]                  o_retire_valid,
    output logic [1:0][PTR_W-1:0]       o_retire_id,
    output logic [PTR_W:0]              o_count,
    output logic                        o_full,
    output logic                        o_empty
);
    logic [PTR_W-1:0] head_q, tail_q, head1, tail1;
    logic [PTR_W:0]   count_q, free_n, alloc_amt, ret_amt;
    logic [1:0]       alloc_n, ret_n;
    logic             alloc_ok, ret0, ret1;
    logic [DEPTH-1:0] valid, complete, alloc_set, cpl_hit, retire_clr;

    always_comb begin
        alloc_n   = (i_alloc_cnt == 2'd3) ? 2'd0 : i_alloc_cnt;
        // Free space uses pre-edge count: same-edge retirements don't help.
        free_n    = (PTR_W+1)'(DEPTH) - count_q;
        alloc_ok  = !i_flush && (alloc_n != 2'd0) && (free_n >= (PTR_W+1)'(alloc_n));
        alloc_amt = alloc_ok ? (PTR_W+1)'(alloc_n) : '0;
        tail1     = tail_q + PTR_W'(1);
        head1     = head_q + PTR_W'(1);
        // Strictly in order: slot1 only behind a retiring slot0.
        ret0      = valid[head_q] && complete[head_q];
        ret1      = ret0 && valid[head1] && complete[head1];
        ret_n     = ret1 ? 2'd2 : (ret0 ? 2'd1 : 2'd0);
        ret_amt   = (PTR_W+1)'(ret_n);
    end

    assign o_alloc_ok  = alloc_ok;
    assign o_alloc_id0 = tail_q;
    assign o_alloc_id1 = tail1;

    for (genvar e = 0; e < DEPTH; e++) begin : g_ent
        logic hit;
        always_comb begin
            hit = 1'b0;
            for (int p = 0; p < CPL_N; p++)
                if (i_cpl_valid[p] && i_cpl_id[p] == PTR_W'(e)) hit = 1'b1;
        end
        assign cpl_hit[e]    = hit;
        assign alloc_set[e]  = alloc_ok && ((tail_q == PTR_W'(e)) ||
                                            (alloc_n == 2'd2 && tail1 == PTR_W'(e)));
        assign retire_clr[e] = (ret0 && head_q == PTR_W'(e)) ||
                               (ret1 && head1 == PTR_W'(e));

        rob_entry u_ent (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .flush      (i_flush),
            .alloc_set  (alloc_set[e]),
            .cpl_hit    (cpl_hit[e]),
            .retire_clr (retire_clr[e]),
            .valid      (valid[e]),
            .complete   (complete[e])
        );
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            o_retire_valid <= '0;
            o_retire_id    <= '0;
        end else if (i_flush) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            o_retire_valid <= '0;
            o_retire_id    <= '0;
        end else begin
            head_q         <= head_q + PTR_W'(ret_n);
            tail_q         <= tail_q + PTR_W'(alloc_amt);
            count_q        <= count_q + alloc_amt - ret_amt;
            o_retire_valid <= {ret1, ret0};
            o_retire_id    <= {head1, head_q};
        end
    end

    assign o_count = count_q;
    assign o_full  = (count_q == (PTR_W+1)'(DEPTH));
    assign o_empty = (count_q == '0);
endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// Directed table-driven bench for rob_alloc_ctrl. Each record is one cycle:
// inputs driven at negedge, comb outputs checked before the edge, registered
// outputs checked 1 time unit after the rising edge.

module tb_rob_alloc_ctrl;
    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      alloc_cnt;
    logic            alloc_ok;
    logic [3:0]      id0, id1;
    logic [2:0]      cpl_valid;
    logic [2:0][3:0] cpl_id;
    logic            flush;
    logic [1:0]      ret_valid;
    logic [1:0][3:0] ret_id;
    logic [4:0]      count;
    logic            full, empty;

    int tests = 0;
    int fails = 0;

    rob_alloc_ctrl #(.DEPTH(16), .PTR_W(4), .CPL_N(3)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_alloc_cnt    (alloc_cnt),
        .o_alloc_ok     (alloc_ok),
        .o_alloc_id0    (id0),
        .o_alloc_id1    (id1),
        .i_cpl_valid    (cpl_valid),
        .i_cpl_id       (cpl_id),
        .i_flush        (flush),
        .o_retire_valid (ret_valid),
        .o_retire_id    (ret_id),
        .o_count        (count),
        .o_full         (full),
        .o_empty        (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        int alloc, cv, c0, c1, c2, fl;
        int ok, id0, id1;
        int rv, r0, r1, cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int alloc, cv, c0, c1, c2, fl,
                       input int ok, e0, e1, rv, r0, r1, cnt);
        vec_t v;
        v.alloc = alloc; v.cv = cv; v.c0 = c0; v.c1 = c1; v.c2 = c2; v.fl = fl;
        v.ok = ok; v.id0 = e0; v.id1 = e1;
        v.rv = rv; v.r0 = r0; v.r1 = r1; v.cnt = cnt;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s vec=%0d got=%0d exp=%0d", name, idx, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; alloc_cnt = '0; cpl_valid = '0; cpl_id = '0; flush = 1'b0;

        // Fill: 8 double allocations fill the ROB, then requests bounce.
        for (int k = 0; k < 8; k++)
            add(2, 0, 0, 0, 0, 0,  1, 2*k, 2*k+1,  0, 0, 0, 2*k+2);
        add(2, 0, 0, 0, 0, 0,  0, 0, 1,  0, 0, 0, 16);       // full, tail stays 0
        add(1, 0, 0, 0, 0, 0,  0, 0, 1,  0, 0, 0, 16);
        // Out-of-order completion: 1 then 0, pair retires after.
        add(0, 1, 1, 0, 0, 0,  0, 0, 1,  0, 0, 0, 16);
        add(0, 2, 0, 0, 0, 0,  0, 0, 1,  0, 0, 0, 16);
        add(0, 0, 0, 0, 0, 0,  0, 0, 1,  3, 0, 1, 14);
        // Ports 0 and 2 on the same edge.
        add(0, 5, 2, 0, 3, 0,  0, 0, 1,  0, 0, 0, 14);
        add(0, 0, 0, 0, 0, 0,  0, 0, 1,  3, 2, 3, 12);
        // Up to count 15, then all-or-nothing.
        add(2, 0, 0, 0, 0, 0,  1, 0, 1,  0, 0, 0, 14);
        add(1, 0, 0, 0, 0, 0,  1, 2, 3,  0, 0, 0, 15);
        add(2, 0, 0, 0, 0, 0,  0, 3, 4,  0, 0, 0, 15);
        add(1, 0, 0, 0, 0, 0,  1, 3, 4,  0, 0, 0, 16);
        // Drain head 4..14.
        add(0, 7, 4, 5, 6, 0,    0, 4, 5,  0, 0, 0, 16);
        add(0, 7, 7, 8, 9, 0,    0, 4, 5,  3, 4, 5, 14);
        add(0, 7, 10, 11, 12, 0, 0, 4, 5,  3, 6, 7, 12);
        add(0, 3, 13, 14, 0, 0,  0, 4, 5,  3, 8, 9, 10);
        add(0, 0, 0, 0, 0, 0,    0, 4, 5,  3, 10, 11, 8);
        add(0, 0, 0, 0, 0, 0,    0, 4, 5,  3, 12, 13, 6);
        add(0, 0, 0, 0, 0, 0,    0, 4, 5,  1, 14, 0, 5);   // 15 incomplete: slot0 only
        // head=15: complete 15,0; completion to id 4 while it is being allocated.
        add(2, 7, 15, 0, 4, 0,   1, 4, 5,  0, 0, 0, 7);
        add(1, 0, 0, 0, 0, 0,    1, 6, 7,  3, 15, 0, 6);   // wrap retire + alloc
        add(3, 7, 1, 2, 3, 0,    0, 7, 8,  0, 0, 0, 6);    // cnt 3 illegal
        add(0, 0, 0, 0, 0, 0,    0, 7, 8,  3, 1, 2, 4);
        add(0, 0, 0, 0, 0, 0,    0, 7, 8,  1, 3, 0, 3);    // 4's completion was dropped
        // Build up to 10 entries, then flush with completions pending.
        add(2, 0, 0, 0, 0, 0,    1, 7, 8,   0, 0, 0, 5);
        add(2, 0, 0, 0, 0, 0,    1, 9, 10,  0, 0, 0, 7);
        add(2, 0, 0, 0, 0, 0,    1, 11, 12, 0, 0, 0, 9);
        add(1, 0, 0, 0, 0, 0,    1, 13, 14, 0, 0, 0, 10);
        add(2, 7, 4, 5, 6, 1,    0, 14, 15, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0,    1, 0, 1,   0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 0,    0, 1, 2,   0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0,    0, 1, 2,   1, 0, 0, 0);
        // Lead-in for the async reset check.
        add(2, 0, 0, 0, 0, 0,    1, 1, 2,   0, 0, 0, 2);
        add(2, 3, 1, 2, 0, 0,    1, 3, 4,   0, 0, 0, 4);
        add(0, 0, 0, 0, 0, 0,    0, 5, 6,   3, 1, 2, 2);

        // Reset state.
        #2;
        chk("rst_count", -1, count, 0);
        chk("rst_empty", -1, empty, 1);
        chk("rst_full",  -1, full, 0);
        chk("rst_rv",    -1, ret_valid, 0);
        chk("rst_id0",   -1, id0, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            @(negedge clk);
            alloc_cnt = 2'(tbl[i].alloc);
            cpl_valid = 3'(tbl[i].cv);
            cpl_id[0] = 4'(tbl[i].c0);
            cpl_id[1] = 4'(tbl[i].c1);
            cpl_id[2] = 4'(tbl[i].c2);
            flush     = tbl[i].fl[0];
            #1;
            chk("alloc_ok",  i, alloc_ok, tbl[i].ok);
            chk("alloc_id0", i, id0, tbl[i].id0);
            chk("alloc_id1", i, id1, tbl[i].id1);
            @(posedge clk);
            #1;
            chk("retire_valid", i, ret_valid, tbl[i].rv);
            if (tbl[i].rv[0]) chk("retire_id0", i, ret_id[0], tbl[i].r0);
            if (tbl[i].rv[1]) chk("retire_id1", i, ret_id[1], tbl[i].r1);
            chk("count", i, count, tbl[i].cnt);
            chk("full",  i, full,  (tbl[i].cnt == 16) ? 1 : 0);
            chk("empty", i, empty, (tbl[i].cnt == 0) ? 1 : 0);
        end

        // Mid-cycle async reset: retire_valid is high and count=2 here.
        alloc_cnt = '0; cpl_valid = '0; flush = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_rv",    0, ret_valid, 0);
        chk("arst_count", 0, count, 0);
        chk("arst_empty", 0, empty, 1);
        chk("arst_id0",   0, id0, 0);
        @(negedge clk);
        rst = 1'b0;
        alloc_cnt = 2'd1;
        #1;
        chk("post_rst_ok",  0, alloc_ok, 1);
        chk("post_rst_id0", 0, id0, 0);
        @(posedge clk);
        #1;
        chk("post_rst_count", 0, count, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
